// File: rtl/sram_responder.sv
// sram_responder: on-chip stand-in for the 16-bit SRAM bus, with a fixed read latency,
// a wrapping access counter and a sticky read/write conflict flag.
module sram_responder #(
    parameter int ADDR_BITS    = 8,
    parameter int READ_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memEnable,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [15:0] addrBus,
    inout  wire  [15:0] dataBus,
    output logic        ready,
    output logic [15:0] accessCount,
    output logic        errFlag
);
    typedef enum logic [2:0] {INIT, IDLE, RD_WAIT, RD_DRIVE, WR_DONE} state_t;
    state_t               r_state, w_next;
    logic [15:0]          r_mem [2**ADDR_BITS];
    logic [ADDR_BITS-1:0] r_ptr, r_addr, w_addr, w_mem_addr;
    logic [3:0]           r_wait;
    logic [15:0]          r_count, w_mem_data;
    logic                 r_err;
    logic                 w_req, w_rd, w_wr, w_conf;
    logic                 w_load, w_inc, w_set_err, w_mem_we, w_unused;
    assign w_addr   = addrBus[ADDR_BITS-1:0];
    assign w_unused = ^addrBus;
    assign w_req    = !memEnable;
    assign w_rd     = w_req && !memRead && memWrite;
    assign w_wr     = w_req && memRead && !memWrite;
    assign w_conf   = w_req && !memRead && !memWrite;
    always_comb begin
        w_next    = r_state;
        w_load    = 1'b0;
        w_inc     = 1'b0;
        w_set_err = 1'b0;
        case (r_state)
            INIT:     w_next = (r_ptr == '1) ? IDLE : INIT;
            IDLE: begin
                w_set_err = w_conf;
                w_load    = w_rd;
                w_inc     = w_rd || w_wr;
                w_next    = w_rd ? RD_WAIT : (w_wr ? WR_DONE : IDLE);
            end
            RD_WAIT:  w_next = (memEnable || memRead) ? IDLE : ((r_wait == 4'd1) ? RD_DRIVE : RD_WAIT);
            RD_DRIVE: begin
                if (w_req && !memWrite) begin
                    w_set_err = 1'b1;
                    w_next    = IDLE;
                end else if (memEnable || memRead) begin
                    w_next = IDLE;
                end else if (w_addr != r_addr) begin
                    // a held read that moves to a new address is a fresh, counted access
                    w_load = 1'b1;
                    w_inc  = 1'b1;
                    w_next = RD_WAIT;
                end
            end
            WR_DONE:  w_next = (memEnable || memWrite) ? IDLE : WR_DONE;
            default:  w_next = INIT;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= INIT;
            r_ptr   <= '0;
            r_addr  <= '0;
            r_wait  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == INIT) r_ptr <= r_ptr + 1'b1;
            if (w_load) begin
                r_addr <= w_addr;
                r_wait <= 4'(READ_LATENCY);
            end else if (r_state == RD_WAIT) begin
                r_wait <= r_wait - 1'b1;
            end
            if (w_inc) r_count <= r_count + 1'b1;
            if (w_set_err) r_err <= 1'b1;
        end
    end
    // the array itself is not reset; INIT sweeps it to zero instead
    assign w_mem_we   = rst && ((r_state == INIT) || (r_state == IDLE && w_wr));
    assign w_mem_addr = (r_state == INIT) ? r_ptr : w_addr;
    assign w_mem_data = (r_state == INIT) ? 16'h0000 : dataBus;
    always_ff @(posedge clk) begin
        if (w_mem_we) r_mem[w_mem_addr] <= w_mem_data;
    end
    assign dataBus     = (r_state == RD_DRIVE && !memEnable && !memRead) ? r_mem[r_addr] : 16'hzzzz;
    assign ready       = (r_state == RD_DRIVE) || (r_state == WR_DONE);
    assign accessCount = r_count;
    assign errFlag     = r_err;
endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: vector table plus hand sequences; read data checked through a scoreboard queue.
// The bus is a pulled-up net, so an undriven bus reads back as 16'hFFFF.
module tb_sram_responder;
    localparam int AB = 8;
    localparam int RL = 2;
    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] data;
        int          hold;
    } vec_t;
    logic        clk = 1'b0, rst = 1'b0, en = 1'b1, rd = 1'b1, wr = 1'b1, drv = 1'b0;
    logic [15:0] addr = 16'h0000, wdata = 16'h0000;
    tri1  [15:0] data_bus;
    logic        ready, err;
    logic [15:0] cnt;
    logic [15:0] exp_cnt = 16'h0000;
    logic [15:0] sb [$];
    int          total = 0, bad = 0;
    vec_t        v [10];
    assign data_bus = drv ? wdata : 16'hzzzz;
    always #5 clk = ~clk;
    sram_responder #(.ADDR_BITS(AB), .READ_LATENCY(RL)) dut (
        .clk(clk), .rst(rst), .memEnable(en), .memRead(rd), .memWrite(wr),
        .addrBus(addr), .dataBus(data_bus), .ready(ready), .accessCount(cnt), .errFlag(err)
    );
    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask
    task automatic bus_idle();
        en = 1'b1; rd = 1'b1; wr = 1'b1; drv = 1'b0;
    endtask
    task automatic wait_ready(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready && n < 400);
    endtask
    task automatic check_read_data(input string name);
        logic [15:0] e;
        e = (sb.size() > 0) ? sb.pop_front() : 16'hxxxx;
        check(name, data_bus, e);
    endtask
    task automatic start_read(input logic [15:0] a, input logic [15:0] e);
        int n;
        en = 1'b0; rd = 1'b0; wr = 1'b1; drv = 1'b0; addr = a;
        sb.push_back(e);
        exp_cnt++;
        wait_ready(n);
        check("rd_latency", 16'(n), 16'(RL + 1));
        check_read_data("rd_data");
    endtask
    task automatic end_read();
        rd = 1'b1;
        #1 check("rd_release_z", data_bus, 16'hFFFF);
        @(negedge clk);
        bus_idle();
        check("rd_ready_low", 16'(ready), 16'h0000);
        check("rd_count", cnt, exp_cnt);
    endtask
    task automatic do_write(input logic [15:0] a, input logic [15:0] d, input int hold);
        en = 1'b0; rd = 1'b1; wr = 1'b0; drv = 1'b1; addr = a; wdata = d;
        exp_cnt++;
        @(negedge clk);
        check("wr_ready", 16'(ready), 16'h0001);
        repeat (hold) begin
            wdata = ~d;
            @(negedge clk);
        end
        bus_idle();
        @(negedge clk);
        check("wr_ready_low", 16'(ready), 16'h0000);
        check("wr_count", cnt, exp_cnt);
    endtask
    // release reset with a read already requested; it must wait out the whole sweep
    task automatic init_check(input logic [15:0] a);
        int n, noisy;
        en = 1'b0; rd = 1'b0; wr = 1'b1; drv = 1'b0; addr = a;
        rst = 1'b1;
        sb.push_back(16'h0000);
        exp_cnt = 16'h0001;
        n = 0;
        noisy = 0;
        do begin
            @(negedge clk);
            n++;
            if (!ready && data_bus !== 16'hFFFF) noisy++;
        end while (!ready && n < 400);
        check("init_latency", 16'(n), 16'((1 << AB) + RL + 1));
        check("init_bus_quiet", 16'(noisy), 16'h0000);
        check_read_data("init_data");
        end_read();
    endtask
    initial begin
        int n, low;
        v[0] = '{1'b1, 16'h0010, 16'hBEEF, 0};
        v[1] = '{1'b0, 16'h0010, 16'hBEEF, 0};
        v[2] = '{1'b1, 16'h0110, 16'h1234, 4};
        v[3] = '{1'b0, 16'h0010, 16'h1234, 0};
        v[4] = '{1'b0, 16'h0042, 16'h0000, 0};
        v[5] = '{1'b1, 16'hFFFF, 16'hA5A5, 0};
        v[6] = '{1'b0, 16'h00FF, 16'hA5A5, 0};
        v[7] = '{1'b1, 16'h0001, 16'h1111, 0};
        v[8] = '{1'b1, 16'h0002, 16'h2222, 0};
        v[9] = '{1'b0, 16'h0001, 16'h1111, 0};
        #3;
        check("rst_ready", 16'(ready), 16'h0000);
        check("rst_count", cnt, 16'h0000);
        check("rst_err", 16'(err), 16'h0000);
        check("rst_bus_z", data_bus, 16'hFFFF);
        repeat (2) @(negedge clk);
        init_check(16'h0042);
        for (int i = 0; i < 10; i++) begin
            if (v[i].wr) do_write(v[i].addr, v[i].data, v[i].hold);
            else begin
                start_read(v[i].addr, v[i].data);
                end_read();
            end
        end
        start_read(16'h0001, 16'h1111);
        addr = 16'h0002;
        sb.push_back(16'h2222);
        exp_cnt++;
        n = 0;
        low = 0;
        do begin
            @(negedge clk);
            n++;
            if (!ready) low++;
        end while (!ready && n < 40);
        check("addr_chg_low_cycles", 16'(low), 16'(RL));
        check_read_data("addr_chg_data");
        end_read();
        en = 1'b0; rd = 1'b0; wr = 1'b0; addr = 16'h0010;
        @(negedge clk);
        check("conflict_err", 16'(err), 16'h0001);
        check("conflict_ready", 16'(ready), 16'h0000);
        check("conflict_count", cnt, exp_cnt);
        bus_idle();
        @(negedge clk);
        start_read(16'h0010, 16'h1234);
        end_read();
        check("err_sticky", 16'(err), 16'h0001);
        start_read(16'h0010, 16'h1234);
        rst = 1'b0;
        #1;
        check("midrst_ready", 16'(ready), 16'h0000);
        check("midrst_bus_z", data_bus, 16'hFFFF);
        check("midrst_count", cnt, 16'h0000);
        check("midrst_err", 16'(err), 16'h0000);
        sb.delete();
        @(negedge clk);
        init_check(16'h0010);
        do_write(16'h0001, 16'h1111, 0);
        start_read(16'h0001, 16'h1111);
        wr = 1'b0;
        @(negedge clk);
        check("drive_wr_err", 16'(err), 16'h0001);
        check("drive_wr_ready", 16'(ready), 16'h0000);
        bus_idle();
        @(negedge clk);
        check("drive_wr_count", cnt, exp_cnt);
        start_read(16'h0001, 16'h1111);
        end_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
